// File: rtl/fir_cfg_master_if.sv
// AXI-Lite (no write-response channel) bundle between the configuration
// master and the fir register slave.
interface fir_cfg_master_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rready;
  logic                   rvalid;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_cfg_master.sv
// Programs the fir block over AXI-Lite: length, coefficients (with
// read-back verification), ap_start, then polls ap_done with a timeout.
module fir_cfg_master #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int POLL_GAP    = 4,
  parameter int POLL_MAX    = 4096
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   start,
  input  logic [31:0]            data_length,
  output logic [3:0]             coef_idx,
  input  logic [pDATA_WIDTH-1:0] coef_data,
  fir_cfg_master_if.master       axil,
  output logic                   busy,
  output logic                   done,
  output logic                   err_coef,
  output logic                   timeout,
  output logic [3:0]             mismatch_cnt
);

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0 = pADDR_WIDTH'(32);
  localparam logic [pDATA_WIDTH-1:0] AP_START  = pDATA_WIDTH'(1);
  localparam logic [3:0]             K_LAST    = 4'(Tape_Num - 1);

  localparam int                PC_W       = $clog2(POLL_MAX + 1);
  localparam logic [PC_W-1:0]   POLL_LIMIT = PC_W'(POLL_MAX);
  localparam int                GC_W       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GC_W-1:0]   GAP_LAST   = GC_W'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LEN, S_WR_TAP, S_RD_TAP, S_WR_START, S_POLL_RD, S_POLL_GAP, S_DONE
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_k;
  logic                   r_awvalid, r_wvalid, r_arvalid, r_rready;
  logic [pADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [pDATA_WIDTH-1:0] r_wdata;
  logic                   r_aw_done, r_w_done, r_ar_done, r_rd_done;
  logic                   r_busy, r_done, r_err, r_timeout;
  logic [3:0]             r_mis;
  logic [PC_W-1:0]        r_poll_cnt;
  logic [GC_W-1:0]        r_gap_cnt;
  logic                   r_ap_done;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_wr_done, w_rd_accept, w_tap_mismatch;

  function automatic logic [pADDR_WIDTH-1:0] tap_addr(input logic [3:0] k);
    return ADDR_TAP0 + pADDR_WIDTH'({k, 2'b00});
  endfunction

  assign w_aw_hs        = r_awvalid & axil.awready;
  assign w_w_hs         = r_wvalid & axil.wready;
  assign w_ar_hs        = r_arvalid & axil.arready;
  // Both write handshakes seen in earlier cycles: this is the advance cycle.
  assign w_wr_done      = r_aw_done & r_w_done;
  // Read data is only taken at or after the address handshake.
  assign w_rd_accept    = r_rready & axil.rvalid & (r_ar_done | w_ar_hs);
  assign w_tap_mismatch = (axil.rdata != coef_data);

  // Sequencer: one transaction at a time, each followed by an advance cycle
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_awaddr   <= '0;
      r_araddr   <= '0;
      r_wdata    <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_ar_done  <= 1'b0;
      r_rd_done  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
      r_mis      <= '0;
      r_poll_cnt <= '0;
      r_gap_cnt  <= '0;
      r_ap_done  <= 1'b0;
    end else begin
      // Each channel drops its own valid right after its own handshake.
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
      if (w_ar_hs) begin
        r_arvalid <= 1'b0;
        r_ar_done <= 1'b1;
      end
      // rready falls once the single beat is taken so no second beat is
      // consumed during the advance cycle.
      if (w_rd_accept) begin
        r_rready  <= 1'b0;
        r_rd_done <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_mis     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_WR_LEN;
            r_awaddr  <= ADDR_LEN;
            r_wdata   <= pDATA_WIDTH'(data_length);
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end

        S_WR_LEN: begin
          if (w_wr_done) begin
            r_state   <= S_WR_TAP;
            r_k       <= '0;
            r_awaddr  <= ADDR_TAP0;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end

        S_WR_TAP: begin
          if (w_wr_done) begin
            if (r_k == K_LAST) begin
              r_state   <= S_RD_TAP;
              r_k       <= '0;
              r_araddr  <= ADDR_TAP0;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
              r_ar_done <= 1'b0;
              r_rd_done <= 1'b0;
            end else begin
              r_k       <= r_k + 4'd1;
              r_awaddr  <= tap_addr(r_k + 4'd1);
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end
          end
        end

        S_RD_TAP: begin
          if (w_rd_accept && w_tap_mismatch) begin
            r_err <= 1'b1;
            if (r_mis != 4'hF) r_mis <= r_mis + 4'd1;
          end
          if (r_rd_done) begin
            if (r_k == K_LAST) begin
              r_state   <= S_WR_START;
              r_k       <= '0;
              r_awaddr  <= ADDR_CTRL;
              r_wdata   <= AP_START;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_k       <= r_k + 4'd1;
              r_araddr  <= tap_addr(r_k + 4'd1);
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
              r_ar_done <= 1'b0;
              r_rd_done <= 1'b0;
            end
          end
        end

        S_WR_START: begin
          if (w_wr_done) begin
            r_state    <= S_POLL_RD;
            r_poll_cnt <= '0;
            r_araddr   <= ADDR_CTRL;
            r_arvalid  <= 1'b1;
            r_rready   <= 1'b1;
            r_ar_done  <= 1'b0;
            r_rd_done  <= 1'b0;
          end
        end

        S_POLL_RD: begin
          if (w_rd_accept) begin
            r_poll_cnt <= r_poll_cnt + 1'b1;
            r_ap_done  <= axil.rdata[1];
          end
          if (r_rd_done) begin
            if (r_ap_done) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (r_poll_cnt == POLL_LIMIT) begin
              r_state   <= S_DONE;
              r_timeout <= 1'b1;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_state   <= S_POLL_GAP;
              r_gap_cnt <= '0;
            end
          end
        end

        S_POLL_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= S_POLL_RD;
            r_arvalid <= 1'b1;
            r_rready  <= 1'b1;
            r_ar_done <= 1'b0;
            r_rd_done <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign axil.awvalid = r_awvalid;
  assign axil.awaddr  = r_awaddr;
  assign axil.wvalid  = r_wvalid;
  // Coefficient writes forward the same-cycle lookup; coef_idx is held for
  // the whole state so the data stays stable while wvalid is high.
  assign axil.wdata   = (r_state == S_WR_TAP) ? coef_data : r_wdata;
  assign axil.arvalid = r_arvalid;
  assign axil.araddr  = r_araddr;
  assign axil.rready  = r_rready;

  assign coef_idx     = r_k;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_coef     = r_err;
  assign timeout      = r_timeout;
  assign mismatch_cnt = r_mis;

endmodule

// File: tb/tb_fir_cfg_master.sv
// Scoreboard bench: stimulus pushes the expected bus transactions, a monitor
// pops and compares each completed write and each read-address handshake.
module tb_fir_cfg_master;
  localparam int NTAP = 11;
  localparam int GAP  = 4;
  localparam int PMAX = 8;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] data_length = '0;
  logic [3:0]  coef_idx;
  logic [31:0] coef_data;
  logic        busy, done, err_coef, timeout;
  logic [3:0]  mismatch_cnt;

  always #5 clk = ~clk;

  fir_cfg_master_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

  fir_cfg_master #(
    .pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(NTAP), .POLL_GAP(GAP), .POLL_MAX(PMAX)
  ) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .start(start), .data_length(data_length),
    .coef_idx(coef_idx), .coef_data(coef_data), .axil(bus), .busy(busy), .done(done),
    .err_coef(err_coef), .timeout(timeout), .mismatch_cnt(mismatch_cnt)
  );

  // ---------------- coefficient source ----------------
  logic [31:0] tap_a [NTAP];
  logic [31:0] tap_b [NTAP];
  logic        tap_sel = 1'b0;
  assign coef_data = (coef_idx < 4'(NTAP)) ? (tap_sel ? tap_b[coef_idx] : tap_a[coef_idx]) : 32'h0;

  // ---------------- slave model ----------------
  int   aw_lat = 0, w_lat = 0, ar_lat = 0, done_after = 0;
  logic early_r = 1'b0, corrupt = 1'b0;
  int   aw_cnt, w_cnt, ar_cnt, poll_seen;
  logic        s_aw_have, s_w_have;
  logic [11:0] s_aw_addr;
  logic [31:0] s_w_data;
  logic [31:0] smem [16];
  logic        aw_got, w_got;
  logic [11:0] aw_a;
  logic [31:0] w_d, rd_val_c;
  logic [3:0]  rd_idx, wr_idx;

  assign bus.awready = bus.awvalid && (aw_cnt >= aw_lat);
  assign bus.wready  = bus.wvalid && (w_cnt >= w_lat);
  assign bus.arready = bus.arvalid && (ar_cnt >= ar_lat);
  assign bus.rvalid  = (bus.arvalid && bus.arready) || (early_r && bus.arvalid);
  assign bus.rdata   = (bus.arvalid && bus.arready) ? rd_val_c : 32'hBAD0_BAD0;

  assign aw_got = s_aw_have || (bus.awvalid && bus.awready);
  assign w_got  = s_w_have || (bus.wvalid && bus.wready);
  assign aw_a   = s_aw_have ? s_aw_addr : bus.awaddr;
  assign w_d    = s_w_have ? s_w_data : bus.wdata;
  assign wr_idx = 4'((aw_a - 12'h020) >> 2);

  always_comb begin
    rd_val_c = 32'h0;
    rd_idx   = 4'((bus.araddr - 12'h020) >> 2);
    if (bus.araddr == 12'h000)
      rd_val_c = (done_after != 0 && poll_seen + 1 == done_after) ? 32'h2 : 32'h0;
    else if (corrupt && bus.araddr == 12'h024)
      rd_val_c = 32'hFFFF_FFF6;
    else if (corrupt && bus.araddr == 12'h02C)
      rd_val_c = 32'h0000_0007;
    else if (bus.araddr >= 12'h020 && bus.araddr < 12'h04C)
      rd_val_c = smem[rd_idx];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; poll_seen <= 0;
      s_aw_have <= 1'b0; s_w_have <= 1'b0; s_aw_addr <= '0; s_w_data <= '0;
    end else begin
      aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
      ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
      if (bus.arvalid && bus.arready && bus.araddr == 12'h000) poll_seen <= poll_seen + 1;
      if (aw_got && w_got) begin
        s_aw_have <= 1'b0;
        s_w_have  <= 1'b0;
        if (aw_a >= 12'h020 && aw_a < 12'h04C) smem[wr_idx] <= w_d;
        if (aw_a == 12'h000) poll_seen <= 0;
      end else begin
        if (bus.awvalid && bus.awready) begin s_aw_have <= 1'b1; s_aw_addr <= bus.awaddr; end
        if (bus.wvalid && bus.wready) begin s_w_have <= 1'b1; s_w_data <= bus.wdata; end
      end
    end
  end

  // ---------------- scoreboard ----------------
  txn_t exp_q[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops one expected entry per completed write / read address
  initial begin
    logic        m_aw_have, m_w_have, prev_aw, prev_w, prev_ar;
    logic [11:0] m_aw_addr;
    logic [31:0] m_w_data;
    int          last_poll;
    txn_t        e;
    m_aw_have = 0; m_w_have = 0; prev_aw = 0; prev_w = 0; prev_ar = 0;
    m_aw_addr = '0; m_w_data = '0; last_poll = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_aw_have = 0; m_w_have = 0; prev_aw = 0; prev_w = 0; prev_ar = 0; last_poll = -1;
      end else begin
        if (prev_aw) chk(!bus.awvalid, "awvalid_drop", 32'(bus.awvalid), 32'h0);
        if (prev_w)  chk(!bus.wvalid, "wvalid_drop", 32'(bus.wvalid), 32'h0);
        if (prev_ar) chk(!bus.arvalid, "arvalid_drop", 32'(bus.arvalid), 32'h0);
        prev_aw = bus.awvalid && bus.awready;
        prev_w  = bus.wvalid && bus.wready;
        prev_ar = bus.arvalid && bus.arready;
        if (prev_aw) begin m_aw_have = 1; m_aw_addr = bus.awaddr; end
        if (prev_w)  begin m_w_have = 1; m_w_data = bus.wdata; end
        if (m_aw_have && m_w_have) begin
          $display("txn wr addr=%h data=%h", m_aw_addr, m_w_data);
          if (exp_q.size() == 0) chk(0, "unexpected_wr", 32'(m_aw_addr), 32'h0);
          else begin
            e = exp_q.pop_front();
            chk(e.wr && e.addr == m_aw_addr, "wr_addr", 32'(m_aw_addr), 32'(e.addr));
            chk(e.wr && e.data == m_w_data, "wr_data", m_w_data, e.data);
          end
          if (m_aw_addr == 12'h000) last_poll = -1;
          m_aw_have = 0; m_w_have = 0;
        end
        if (prev_ar) begin
          $display("txn rd addr=%h data=%h", bus.araddr, bus.rdata);
          if (exp_q.size() == 0) chk(0, "unexpected_rd", 32'(bus.araddr), 32'h0);
          else begin
            e = exp_q.pop_front();
            chk(!e.wr && e.addr == bus.araddr, "rd_addr", 32'(bus.araddr), 32'(e.addr));
          end
          if (bus.araddr == 12'h000) begin
            if (last_poll >= 0) chk(cyc - last_poll >= GAP + 1, "poll_gap", 32'(cyc - last_poll), 32'(GAP + 1));
            last_poll = cyc;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_flow(input logic [31:0] len, input int npoll);
    txn_t t;
    t = '{wr: 1'b1, addr: 12'h010, data: len};
    exp_q.push_back(t);
    for (int k = 0; k < NTAP; k++) begin
      t = '{wr: 1'b1, addr: 12'(32'h20 + 4 * k), data: tap_sel ? tap_b[k] : tap_a[k]};
      exp_q.push_back(t);
    end
    for (int k = 0; k < NTAP; k++) begin
      t = '{wr: 1'b0, addr: 12'(32'h20 + 4 * k), data: 32'h0};
      exp_q.push_back(t);
    end
    t = '{wr: 1'b1, addr: 12'h000, data: 32'h1};
    exp_q.push_back(t);
    for (int p = 0; p < npoll; p++) begin
      t = '{wr: 1'b0, addr: 12'h000, data: 32'h0};
      exp_q.push_back(t);
    end
  endtask

  task automatic pulse_start(input logic [31:0] len);
    @(negedge clk);
    start = 1'b1;
    data_length = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(seen, name, 32'(seen), 32'h1);
  endtask

  task automatic check_final(input string name, input bit e_err, input bit e_to, input logic [3:0] e_mis);
    $display("check %s", name);
    chk(done == 1'b1, "done", 32'(done), 32'h1);
    chk(busy == 1'b0, "busy", 32'(busy), 32'h0);
    chk(err_coef == e_err, "err_coef", 32'(err_coef), 32'(e_err));
    chk(timeout == e_to, "timeout", 32'(timeout), 32'(e_to));
    chk(mismatch_cnt == e_mis, "mismatch_cnt", 32'(mismatch_cnt), 32'(e_mis));
    chk(exp_q.size() == 0, "txn_left", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    bit found;
    int a_init [NTAP] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    for (int k = 0; k < NTAP; k++) begin
      tap_a[k] = 32'(a_init[k]);
      tap_b[k] = 32'(k + 1);
    end

    // Reset state
    #1;
    chk(!bus.awvalid && !bus.wvalid && !bus.arvalid && !bus.rready, "rst_valids",
        {28'h0, bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 32'h0);
    chk(bus.awaddr == 0 && bus.araddr == 0 && bus.wdata == 0, "rst_bus", 32'(bus.awaddr) | 32'(bus.araddr) | bus.wdata, 32'h0);
    chk({busy, done, err_coef, timeout} == 4'h0, "rst_flags", 32'({busy, done, err_coef, timeout}), 32'h0);
    chk(mismatch_cnt == 0 && coef_idx == 0, "rst_cnt", 32'({mismatch_cnt, coef_idx}), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: zero-wait slave, ap_done on the 3rd poll
    $display("run zero_wait");
    done_after = 3;
    push_flow(32'd600, 3);
    pulse_start(32'd600);
    chk(busy == 1'b1, "busy_after_start", 32'(busy), 32'h1);
    wait_done("done_zero_wait");
    check_final("zero_wait", 0, 0, 4'd0);

    // 2a: wready 3 cycles before awready
    $display("run w_before_aw");
    aw_lat = 3; w_lat = 0;
    push_flow(32'd600, 3);
    pulse_start(32'd600);
    wait_done("done_w_first");
    check_final("w_before_aw", 0, 0, 4'd0);

    // 2b: awready 3 cycles before wready
    $display("run aw_before_w");
    aw_lat = 0; w_lat = 3;
    push_flow(32'd600, 3);
    pulse_start(32'd600);
    wait_done("done_aw_first");
    check_final("aw_before_w", 0, 0, 4'd0);
    w_lat = 0;

    // 3: read-back corrupted at 0x24 and 0x2C (taps 1..11 here)
    $display("run corrupt");
    tap_sel = 1'b1; corrupt = 1'b1;
    push_flow(32'd77, 3);
    pulse_start(32'd77);
    wait_done("done_corrupt");
    check_final("corrupt", 1, 0, 4'd2);
    tap_sel = 1'b0; corrupt = 1'b0;

    // 4: ap_done never set -> PMAX polls then timeout
    $display("run timeout");
    done_after = 0;
    push_flow(32'd600, PMAX);
    pulse_start(32'd600);
    wait_done("done_timeout");
    check_final("timeout", 0, 1, 4'd0);

    // 5: reset while awvalid is high in WR_TAP k=5
    $display("run reset_mid");
    done_after = 3; aw_lat = 2; w_lat = 2;
    push_flow(32'd600, 3);
    pulse_start(32'd600);
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bus.awvalid && bus.awaddr == 12'h034 && !bus.awready) found = 1;
    end
    chk(found, "reach_tap5", 32'(found), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk(!bus.awvalid && !bus.wvalid && !bus.arvalid && !bus.rready, "reset_drops_valids",
        {28'h0, bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 32'h0);
    chk(busy == 1'b0 && coef_idx == 0, "reset_busy_idx", 32'({busy, coef_idx}), 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_flow(32'd600, 3);
    pulse_start(32'd600);
    repeat (20) @(negedge clk);
    pulse_start(32'd999);
    chk(busy == 1'b1, "busy_during_run", 32'(busy), 32'h1);
    repeat (25) @(negedge clk);
    pulse_start(32'd999);
    wait_done("done_after_reset");
    check_final("reset_rerun", 0, 0, 4'd0);
    aw_lat = 0; w_lat = 0;

    // 6: rvalid presented before arready with bogus data
    $display("run early_rvalid");
    early_r = 1'b1; ar_lat = 2;
    push_flow(32'd600, 3);
    pulse_start(32'd600);
    wait_done("done_early_r");
    check_final("early_rvalid", 0, 0, 4'd0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
